mfp_ahb_master: RTL and testbench

//  AHB-lite bus initiator: turns a valid/ready command stream (single read/write) into AHB-lite

---
 rtl/mfp_ahb_master_pkg.sv | 27 ++
 rtl/mfp_ahb_master_if.sv | 47 ++++
 rtl/mfp_ahb_master_align.sv | 12 +
 rtl/mfp_ahb_master.sv | 160 ++++++++++++++++
 tb/tb_mfp_ahb_master.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_ahb_master_pkg.sv
// Shared AHB-lite encodings, FSM state type and the size/alignment rule for mfp_ahb_master.
package mfp_ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_8       = 3'b000;
  localparam logic [2:0] HSIZE_16      = 3'b001;
  localparam logic [2:0] HSIZE_32      = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic {StRun, StErr2} state_e;

  function automatic logic size_addr_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic legal;
    case ({1'b0, size})
      HSIZE_8:  legal = 1'b1;
      HSIZE_16: legal = ~addr_lo[0];
      HSIZE_32: legal = (addr_lo == 2'b00);
      default:  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mfp_ahb_master_if.sv
// Command/response stream plus AHB-lite master signals; master modport is the initiator's view.
interface mfp_ahb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_abort;

  logic [ADDR_W-1:0] HADDR;
  logic [2:0]        HBURST;
  logic              HMASTLOCK;
  logic [3:0]        HPROT;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_abort,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_abort,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/mfp_ahb_master_align.sv
// Flags commands whose size/address combination cannot be issued on the bus.
module mfp_ahb_master_align
  import mfp_ahb_master_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic       o_legal
);

  assign o_legal = size_addr_legal(i_size, i_addr_lo);

endmodule

// File: rtl/mfp_ahb_master.sv
// AHB-lite initiator: pipelined address (AP) and data (DP) phase registers, in-order responses.
module mfp_ahb_master
  import mfp_ahb_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  mfp_ahb_master_if.master bus
);

  state_e            r_state;
  logic              r_ap_valid;
  logic              r_ap_write;
  logic              r_ap_legal;
  logic [ADDR_W-1:0] r_ap_addr;
  logic [1:0]        r_ap_size;
  logic [DATA_W-1:0] r_ap_wdata;
  logic              r_dp_valid;
  logic              r_dp_write;
  logic              r_dp_phantom;
  logic [DATA_W-1:0] r_dp_wdata;
  logic [1:0]        r_htrans;

  logic              w_cmd_legal;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_dp_real;
  logic              w_err_first;
  state_e            w_state_d;
  logic              w_ap_valid_d;
  logic              w_ap_legal_d;
  logic              w_dp_valid_d;
  logic              w_dp_phantom_d;
  logic              w_dp_load;
  logic [1:0]        w_htrans_d;
  logic              w_rsp_valid;
  logic              w_rsp_err;
  logic              w_rsp_abort;
  logic [DATA_W-1:0] w_rsp_rdata;

  mfp_ahb_master_align u_align (
    .i_size    (bus.cmd_size),
    .i_addr_lo (bus.cmd_addr[1:0]),
    .o_legal   (w_cmd_legal)
  );

  assign w_cmd_ready = !HRESET && (r_state == StRun) && (!r_ap_valid || bus.HREADY);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  // A phantom DP entry never had a bus data phase: it is a rejected or cancelled command
  // queued behind earlier ones so that its response keeps acceptance order.
  assign w_dp_real   = r_dp_valid && !r_dp_phantom;
  assign w_err_first = (r_state == StRun) && w_dp_real && (bus.HRESP == HRESP_ERROR) &&
                       !bus.HREADY;

  always_comb begin
    w_state_d      = r_state;
    w_ap_valid_d   = r_ap_valid;
    w_ap_legal_d   = r_ap_legal;
    w_dp_valid_d   = r_dp_valid;
    w_dp_phantom_d = r_dp_phantom;
    w_dp_load      = 1'b0;
    if (r_state == StRun) begin
      if (bus.HREADY) begin
        w_dp_load      = r_ap_valid;
        w_dp_valid_d   = r_ap_valid;
        w_dp_phantom_d = !r_ap_legal;
        w_ap_valid_d   = 1'b0;
      end else if (r_dp_phantom) begin
        w_dp_valid_d = 1'b0;
      end
      if (w_err_first) begin
        w_state_d = StErr2;
      end
      if (w_accept) begin
        w_ap_valid_d = 1'b1;
        w_ap_legal_d = w_cmd_legal;
      end
    end else if (bus.HREADY) begin
      // Error completes: the pending address-phase command is cancelled, reported next cycle.
      w_dp_load      = r_ap_valid;
      w_dp_valid_d   = r_ap_valid;
      w_dp_phantom_d = 1'b1;
      w_ap_valid_d   = 1'b0;
      w_state_d      = StRun;
    end
    w_htrans_d = (w_state_d == StRun && w_ap_valid_d && w_ap_legal_d) ? HTRANS_NONSEQ
                                                                     : HTRANS_IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= StRun;
      r_ap_valid   <= 1'b0;
      r_ap_write   <= 1'b0;
      r_ap_legal   <= 1'b0;
      r_ap_addr    <= '0;
      r_ap_size    <= 2'b00;
      r_ap_wdata   <= '0;
      r_dp_valid   <= 1'b0;
      r_dp_write   <= 1'b0;
      r_dp_phantom <= 1'b0;
      r_dp_wdata   <= '0;
      r_htrans     <= HTRANS_IDLE;
    end else begin
      r_state      <= w_state_d;
      r_ap_valid   <= w_ap_valid_d;
      r_ap_legal   <= w_ap_legal_d;
      r_dp_valid   <= w_dp_valid_d;
      r_dp_phantom <= w_dp_phantom_d;
      r_htrans     <= w_htrans_d;
      if (w_accept) begin
        r_ap_write <= bus.cmd_write;
        r_ap_addr  <= bus.cmd_addr;
        r_ap_size  <= bus.cmd_size;
        r_ap_wdata <= bus.cmd_wdata;
      end
      if (w_dp_load) begin
        r_dp_write <= r_ap_write;
        r_dp_wdata <= r_ap_wdata;
      end
    end
  end

  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_abort = 1'b0;
    w_rsp_rdata = '0;
    if (!HRESET && r_dp_valid) begin
      if (r_dp_phantom) begin
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
        w_rsp_abort = 1'b1;
      end else if (bus.HREADY) begin
        w_rsp_valid = 1'b1;
        w_rsp_err   = (bus.HRESP == HRESP_ERROR) || (r_state == StErr2);
        if (!w_rsp_err && !r_dp_write && (bus.HRESP == HRESP_OKAY)) begin
          w_rsp_rdata = bus.HRDATA;
        end
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_err   = w_rsp_err;
  assign bus.rsp_abort = w_rsp_abort;
  assign bus.rsp_rdata = w_rsp_rdata;
  assign bus.HADDR     = r_ap_addr;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_DATA;
  assign bus.HSIZE     = {1'b0, r_ap_size};
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_ap_write;
  assign bus.HWDATA    = r_dp_wdata;

endmodule

// File: tb/tb_mfp_ahb_master.sv
// Directed bench for mfp_ahb_master: RAM/peripheral slave model and an in-order response scoreboard.
module tb_mfp_ahb_master;
  import mfp_ahb_master_pkg::*;

  localparam logic [31:0] PERIPH     = 32'h1F80_0000;
  localparam logic [31:0] PERIPH_VAL = 32'h1F80_CAFE;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        abort;
  } rsp_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  mfp_ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mfp_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Slave model: RAM at 0x00-0xFF, one peripheral word with configurable waits/error.
  logic [31:0] mem_lo [64];
  logic        mem_init_done = 1'b0;
  logic        s_dp_valid, s_dp_write, s_err, s_err2;
  logic [31:0] s_dp_addr;
  int          s_cnt;
  int          cap_cnt = 0;
  int          cfg_waits;
  logic        cfg_err;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (a[31:8] == 24'h0) return mem_lo[a[7:2]];
    if (a == PERIPH) return PERIPH_VAL;
    return 32'h0;
  endfunction

  always_comb begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    if (s_dp_valid) begin
      if (s_cnt != 0) begin
        bus.HREADY = 1'b0;
      end else if (s_err && !s_err2) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
      end else if (s_err) begin
        bus.HRESP = 1'b1;
      end else if (!s_dp_write) begin
        bus.HRDATA = slave_rd(s_dp_addr);
      end
    end
  end

  always @(posedge HCLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem_lo[i] <= 32'h0;
      mem_lo[0] <= 32'h1122_3344;
      mem_lo[5] <= 32'h5566_7788;
      mem_lo[6] <= 32'h99AA_BBCC;
      mem_lo[7] <= 32'h0BAD_F00D;
      mem_init_done <= 1'b1;
    end
    if (HRESET) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= 32'h0;
      s_cnt      <= 0;
      s_err      <= 1'b0;
      s_err2     <= 1'b0;
    end else if (bus.HREADY) begin
      if (s_dp_valid && s_dp_write && !s_err && s_dp_addr[31:8] == 24'h0)
        mem_lo[s_dp_addr[7:2]] <= bus.HWDATA;
      s_dp_valid <= (bus.HTRANS == HTRANS_NONSEQ);
      s_dp_addr  <= bus.HADDR;
      s_dp_write <= bus.HWRITE;
      s_cnt      <= (bus.HADDR == PERIPH) ? cfg_waits : 0;
      s_err      <= (bus.HADDR == PERIPH) && cfg_err;
      s_err2     <= 1'b0;
      if (bus.HTRANS == HTRANS_NONSEQ) cap_cnt <= cap_cnt + 1;
    end else if (s_dp_valid) begin
      if (s_cnt != 0) s_cnt <= s_cnt - 1;
      else if (s_err) s_err2 <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (bus.rsp_valid === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        check("rsp_abort", {31'h0, bus.rsp_abort}, {31'h0, e.abort});
      end
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
    check_rsp();
  endtask

  // Offers a command from a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [31:0] e_rdata, input logic e_err,
                       input logic e_abort, output int stalls);
    stalls        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = size;
    bus.cmd_wdata = wdata;
    #1;
    while (bus.cmd_ready !== 1'b1 && stalls < 50) begin
      tick();
      #1;
      stalls++;
    end
    tests++;
    assert (bus.cmd_ready === 1'b1) else begin
      fails++;
      $error("FAIL cmd_accept_timeout: observed cmd_ready=%b expected 1", bus.cmd_ready);
    end
    if (bus.cmd_ready === 1'b1) begin
      sb.push_back('{rdata: e_rdata, err: e_err, abort: e_abort});
      tick();
    end else begin
      bus.cmd_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          st;
    int          c0;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];
    logic [31:0] mis_addr [3];
    logic [1:0]  mis_size [3];

    b2b_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
    b2b_data = '{32'hDEAD_BEEF, 32'h5566_7788, 32'h99AA_BBCC, 32'h0BAD_F00D};
    mis_addr = '{32'h2, 32'h1, 32'h0};
    mis_size = '{2'd2, 2'd1, 2'd3};

    cfg_waits     = 0;
    cfg_err       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_size  = 2'd0;
    bus.cmd_wdata = 32'h0;

    // Reset state
    repeat (3) tick();
    check("reset_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("reset_hprot", {28'h0, bus.HPROT}, 32'h3);
    check("reset_haddr", bus.HADDR, 32'h0);
    check("reset_hburst", {29'h0, bus.HBURST}, 32'h0);
    check("reset_hmastlock", {31'h0, bus.HMASTLOCK}, 32'h0);
    check("reset_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    HRESET = 1'b0;
    #1;
    check("ready_after_reset", {31'h0, bus.cmd_ready}, 32'h1);
    tick();

    // Write then read back
    issue(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, st);
    bus.cmd_valid = 1'b0;
    check("wr_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("wr_haddr", bus.HADDR, 32'h10);
    check("wr_hwrite", {31'h0, bus.HWRITE}, 32'h1);
    check("wr_hsize", {29'h0, bus.HSIZE}, 32'h2);
    check("wr_rsp_early", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    check("wr_rsp_latency", {31'h0, bus.rsp_valid}, 32'h1);
    check("wr_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
    issue(1'b0, 32'h10, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, st);
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    check("wr_mem", mem_lo[4], 32'hDEAD_BEEF);

    // Back-to-back reads, zero waits
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, b2b_addr[k], 2'd2, 32'h0, b2b_data[k], 1'b0, 1'b0, st);
      check("b2b_stall", st, 0);
      check("b2b_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
      if (k > 0) check("b2b_rsp_pulse", {31'h0, bus.rsp_valid}, 32'h1);
    end
    bus.cmd_valid = 1'b0;
    tick();
    check("b2b_rsp_last", {31'h0, bus.rsp_valid}, 32'h1);
    tick();
    check("b2b_rsp_done", {31'h0, bus.rsp_valid}, 32'h0);

    // Three wait states on the peripheral, second read held in the address phase
    cfg_waits = 3;
    issue(1'b0, PERIPH, 2'd2, 32'h0, PERIPH_VAL, 1'b0, 1'b0, st);
    issue(1'b0, 32'h14, 2'd2, 32'h0, 32'h5566_7788, 1'b0, 1'b0, st);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
      check("wait_haddr", bus.HADDR, 32'h14);
      check("wait_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      tick();
    end
    check("wait_rsp_late", {31'h0, bus.rsp_valid}, 32'h1);
    tick();
    check("wait_rsp_second", {31'h0, bus.rsp_valid}, 32'h1);
    cfg_waits = 0;
    tick();

    // Slave ERROR with a command pipelined behind it
    cfg_err = 1'b1;
    c0 = cap_cnt;
    issue(1'b0, PERIPH, 2'd2, 32'h0, 32'h0, 1'b1, 1'b0, st);
    issue(1'b0, 32'h14, 2'd2, 32'h0, 32'h0, 1'b1, 1'b1, st);
    bus.cmd_valid = 1'b0;
    check("err_first_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    check("err2_htrans_idle", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("err2_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("err2_rsp_a", {31'h0, bus.rsp_valid}, 32'h1);
    tick();
    check("err_rsp_b", {31'h0, bus.rsp_valid}, 32'h1);
    tick();
    check("err_b_not_issued", cap_cnt - c0, 1);
    cfg_err = 1'b0;

    // Illegal size/alignment: never reaches the bus
    for (int k = 0; k < 3; k++) begin
      c0 = cap_cnt;
      issue(1'b0, mis_addr[k], mis_size[k], 32'h0, 32'h0, 1'b1, 1'b1, st);
      bus.cmd_valid = 1'b0;
      check("mis_htrans_idle", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
      tick();
      check("mis_rsp", {31'h0, bus.rsp_valid}, 32'h1);
      tick();
      check("mis_no_xfer", cap_cnt - c0, 0);
    end
    issue(1'b0, 32'h3, 2'd0, 32'h0, 32'h1122_3344, 1'b0, 1'b0, st);
    issue(1'b0, 32'h18, 2'd2, 32'h0, 32'h99AA_BBCC, 1'b0, 1'b0, st);
    issue(1'b1, 32'h6, 2'd2, 32'h1234_5678, 32'h0, 1'b1, 1'b1, st);
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check("mis_mem_untouched", mem_lo[1], 32'h0);

    // Reset during a wait state with a second command held in the address phase
    cfg_waits = 5;
    issue(1'b0, PERIPH, 2'd2, 32'h0, PERIPH_VAL, 1'b0, 1'b0, st);
    issue(1'b0, 32'h14, 2'd2, 32'h0, 32'h5566_7788, 1'b0, 1'b0, st);
    bus.cmd_valid = 1'b0;
    check("rstw_htrans_before", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    HRESET = 1'b1;
    sb.delete();
    #1;
    check("rstw_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("rstw_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    check("rstw_htrans_idle", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("rstw_cmd_ready2", {31'h0, bus.cmd_ready}, 32'h0);
    check("rstw_rsp_valid2", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    HRESET = 1'b0;
    cfg_waits = 0;
    #1;
    check("rstw_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
    repeat (3) tick();
    issue(1'b0, 32'h1C, 2'd2, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, st);
    bus.cmd_valid = 1'b0;
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
